cpu_datapath: RTL and testbench

- 32-bit single-bus CPU datapath slice: general registers R1–R3, PC, IR, Y, 64-bit Z (ZHigh/ZLow), MDR and HI share one internal bus.
- External control signals, driven one cycle at a time by a control unit or bench, gate register outputs onto the bus and load registers from it.
- The ALU implements bitwise AND of Y and the bus into Z.
- Used to run multi-cycle instruction sequences (fetch T0–T2, execute T3–T6).

---
 rtl/cpu_datapath_pkg.sv | 14 +
 rtl/dp_reg32.sv | 18 +
 rtl/cpu_datapath.sv | 74 +++++++
 tb/tb_cpu_datapath.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpu_datapath_pkg.sv
// cpu_datapath_pkg: shared width and bus-select encoding for the datapath slice
package cpu_datapath_pkg;
    localparam int DP_WIDTH = 32;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MDR,
        SEL_PC,
        SEL_ZLO,
        SEL_ZHI,
        SEL_R2,
        SEL_R3
    } bus_sel_t;
endpackage

// File: rtl/dp_reg32.sv
// dp_reg32: load-enabled register with asynchronous active-low clear
module dp_reg32
    import cpu_datapath_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // capture d on enabled edges, hold otherwise
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit datapath slice with AND ALU into 64-bit Z
module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [WIDTH-1:0]   Mdatain,
    input  logic               Read,
    input  logic               MDRin,
    input  logic               IRin,
    input  logic               Yin,
    input  logic               R1in,
    input  logic               R2in,
    input  logic               R3in,
    input  logic               HIin,
    input  logic               AND,
    input  logic               PCout,
    input  logic               MDRout,
    input  logic               Zlowout,
    input  logic               ZHighout,
    input  logic               R2out,
    input  logic               R3out,
    output logic [WIDTH-1:0]   bus_out,
    output logic [WIDTH-1:0]   r1_q,
    output logic [WIDTH-1:0]   r2_q,
    output logic [WIDTH-1:0]   r3_q,
    output logic [WIDTH-1:0]   ir_q,
    output logic [WIDTH-1:0]   y_q,
    output logic [WIDTH-1:0]   hi_q,
    output logic [WIDTH-1:0]   mdr_q,
    output logic [WIDTH-1:0]   pc_q,
    output logic [2*WIDTH-1:0] z_q
);
    bus_sel_t         sel;
    logic [WIDTH-1:0] mdr_d;

    // fixed-priority choice of which register drives the bus
    always_comb begin
        sel = MDRout   ? SEL_MDR :
              PCout    ? SEL_PC  :
              Zlowout  ? SEL_ZLO :
              ZHighout ? SEL_ZHI :
              R2out    ? SEL_R2  :
              R3out    ? SEL_R3  : SEL_NONE;
    end

    // bus mux; an idle bus reads as zero
    always_comb begin
        bus_out = (sel == SEL_MDR) ? mdr_q :
                  (sel == SEL_PC)  ? pc_q :
                  (sel == SEL_ZLO) ? z_q[WIDTH-1:0] :
                  (sel == SEL_ZHI) ? z_q[2*WIDTH-1:WIDTH] :
                  (sel == SEL_R2)  ? r2_q :
                  (sel == SEL_R3)  ? r3_q : '0;
    end

    assign mdr_d = Read ? Mdatain : bus_out;

    // PC has no load path in this slice, so it stays at its reset value
    dp_reg32 #(.WIDTH(WIDTH)) u_pc  (.clock(clock), .clear(clear), .load(1'b0),  .d('0),      .q(pc_q));
    dp_reg32 #(.WIDTH(WIDTH)) u_ir  (.clock(clock), .clear(clear), .load(IRin),  .d(bus_out), .q(ir_q));
    dp_reg32 #(.WIDTH(WIDTH)) u_y   (.clock(clock), .clear(clear), .load(Yin),   .d(bus_out), .q(y_q));
    dp_reg32 #(.WIDTH(WIDTH)) u_mdr (.clock(clock), .clear(clear), .load(MDRin), .d(mdr_d),   .q(mdr_q));
    dp_reg32 #(.WIDTH(WIDTH)) u_hi  (.clock(clock), .clear(clear), .load(HIin),  .d(bus_out), .q(hi_q));
    dp_reg32 #(.WIDTH(WIDTH)) u_r1  (.clock(clock), .clear(clear), .load(R1in),  .d(bus_out), .q(r1_q));
    dp_reg32 #(.WIDTH(WIDTH)) u_r2  (.clock(clock), .clear(clear), .load(R2in),  .d(bus_out), .q(r2_q));
    dp_reg32 #(.WIDTH(WIDTH)) u_r3  (.clock(clock), .clear(clear), .load(R3in),  .d(bus_out), .q(r3_q));

    // AND result lands in the low half; the high half is zero-extended
    dp_reg32 #(.WIDTH(WIDTH)) u_zlo (.clock(clock), .clear(clear), .load(AND), .d(y_q & bus_out), .q(z_q[WIDTH-1:0]));
    dp_reg32 #(.WIDTH(WIDTH)) u_zhi (.clock(clock), .clear(clear), .load(AND), .d('0),            .q(z_q[2*WIDTH-1:WIDTH]));
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed test-plan sequence plus random control traffic against a reference model
module tb_cpu_datapath;
    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] Mdatain = '0;
    logic        Read = 0, MDRin = 0, IRin = 0, Yin = 0, R1in = 0, R2in = 0, R3in = 0, HIin = 0, AND = 0;
    logic        PCout = 0, MDRout = 0, Zlowout = 0, ZHighout = 0, R2out = 0, R3out = 0;
    logic [31:0] bus_out, r1_q, r2_q, r3_q, ir_q, y_q, hi_q, mdr_q, pc_q;
    logic [63:0] z_q;

    localparam logic [14:0] C_READ = 15'h4000, C_MDRIN = 15'h2000, C_IRIN = 15'h1000, C_YIN = 15'h0800,
                            C_R1IN = 15'h0400, C_R2IN = 15'h0200, C_R3IN = 15'h0100, C_HIIN = 15'h0080,
                            C_AND = 15'h0040, C_PCOUT = 15'h0020, C_MDROUT = 15'h0010, C_ZLO = 15'h0008,
                            C_ZHI = 15'h0004, C_R2OUT = 15'h0002, C_R3OUT = 15'h0001;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_r1, m_r2, m_r3, m_ir, m_y, m_hi, m_mdr, m_pc;
    logic [63:0] m_z;

    cpu_datapath dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .R1in(R1in), .R2in(R2in), .R3in(R3in), .HIin(HIin), .AND(AND), .PCout(PCout),
        .MDRout(MDRout), .Zlowout(Zlowout), .ZHighout(ZHighout), .R2out(R2out), .R3out(R3out),
        .bus_out(bus_out), .r1_q(r1_q), .r2_q(r2_q), .r3_q(r3_q), .ir_q(ir_q), .y_q(y_q),
        .hi_q(hi_q), .mdr_q(mdr_q), .pc_q(pc_q), .z_q(z_q)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r1 = 0; m_r2 = 0; m_r3 = 0; m_ir = 0; m_y = 0; m_hi = 0; m_mdr = 0; m_pc = 0; m_z = 0;
    endtask

    // first asserted select in priority order wins; nothing asserted reads zero
    function automatic logic [31:0] model_bus();
        logic        sels [6];
        logic [31:0] vals [6];
        sels = '{MDRout, PCout, Zlowout, ZHighout, R2out, R3out};
        vals = '{m_mdr, m_pc, m_z[31:0], m_z[63:32], m_r2, m_r3};
        for (int i = 0; i < 6; i++) if (sels[i]) return vals[i];
        return 32'h0;
    endfunction

    task automatic check_regs(input string pfx);
        chk({pfx, ".r1"}, {32'h0, r1_q}, {32'h0, m_r1});
        chk({pfx, ".r2"}, {32'h0, r2_q}, {32'h0, m_r2});
        chk({pfx, ".r3"}, {32'h0, r3_q}, {32'h0, m_r3});
        chk({pfx, ".ir"}, {32'h0, ir_q}, {32'h0, m_ir});
        chk({pfx, ".y"}, {32'h0, y_q}, {32'h0, m_y});
        chk({pfx, ".hi"}, {32'h0, hi_q}, {32'h0, m_hi});
        chk({pfx, ".mdr"}, {32'h0, mdr_q}, {32'h0, m_mdr});
        chk({pfx, ".pc"}, {32'h0, pc_q}, {32'h0, m_pc});
        chk({pfx, ".z"}, z_q, m_z);
    endtask

    task automatic set_ctl(input logic [14:0] c, input logic [31:0] md);
        {Read, MDRin, IRin, Yin, R1in, R2in, R3in, HIin, AND, PCout, MDRout, Zlowout, ZHighout, R2out, R3out} = c;
        Mdatain = md;
    endtask

    // one control cycle: drive after the falling edge, check bus, clock it, check registers
    task automatic cyc(input logic [14:0] c, input logic [31:0] md, input bit pulse_clear);
        logic [31:0] eb;
        @(negedge clock);
        set_ctl(c, md);
        #1;
        eb = model_bus();
        chk("bus", {32'h0, bus_out}, {32'h0, eb});
        @(posedge clock);
        if (AND) m_z = {32'h0, m_y & eb};
        if (MDRin) m_mdr = Read ? md : eb;
        if (IRin) m_ir = eb;
        if (Yin) m_y = eb;
        if (R1in) m_r1 = eb;
        if (R2in) m_r2 = eb;
        if (R3in) m_r3 = eb;
        if (HIin) m_hi = eb;
        #1;
        check_regs("cyc");
        if (pulse_clear) begin
            #2 clear = 1'b0;
            #1;
            model_reset();
            check_regs("clr");
            clear = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        set_ctl(15'h7fff, 32'hdead_beef);
        repeat (2) @(posedge clock);
        #1;
        check_regs("rst");
        chk("rst.bus", {32'h0, bus_out}, 64'h0);
        @(negedge clock);
        set_ctl('0, '0);
        clear = 1'b1;
        cyc('0, 32'hffff_ffff, 0);

        cyc(C_READ | C_MDRIN, 32'h12, 0);
        cyc(C_MDROUT | C_R2IN, 32'h0, 0);
        cyc(C_READ | C_MDRIN, 32'h14, 0);
        cyc(C_MDROUT | C_R3IN, 32'h0, 0);
        cyc(C_READ | C_MDRIN, 32'h18, 0);
        cyc(C_MDROUT | C_R1IN, 32'h0, 0);
        cyc(C_R2OUT | C_YIN, 32'h0, 0);
        cyc(C_R3OUT | C_AND, 32'h0, 0);
        chk("and.z", z_q, 64'h10);
        cyc(C_ZLO | C_R1IN, 32'h0, 0);
        chk("and.r1", {32'h0, r1_q}, 64'h10);
        cyc(C_ZHI | C_HIIN, 32'h0, 0);
        chk("hi", {32'h0, hi_q}, 64'h0);
        cyc(C_PCOUT, 32'h0, 0);
        cyc(C_READ | C_MDRIN, 32'h9, 0);
        cyc(C_MDROUT | C_IRIN, 32'h0, 0);
        chk("fetch.ir", {32'h0, ir_q}, 64'h9);
        cyc(C_MDROUT | C_R2OUT, 32'h0, 0);
        cyc(C_MDROUT | C_MDRIN, 32'h0, 0);
        repeat (3) cyc('0, 32'h5555_aaaa, 0);
        cyc('0, 32'h0, 1);

        for (int k = 0; k < 400; k++)
            cyc(15'($urandom & $urandom), $urandom, ($urandom_range(0, 39) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
